// File: rtl/ft_tx_stream.sv
// ft_tx_stream: sample FIFO plus FT600 245-synchronous write engine.
// Samples enter through a valid/ready port and are drained to the FT600
// in bursts gated by txe_n. wr_n, be, ft_oe and ft_data are registered.
module ft_tx_stream #(
    parameter int DATA_W     = 16,
    parameter int BE_W       = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_MIN  = 8,
    parameter int MAX_BURST  = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          txe_n,
    output logic [DATA_W-1:0]             ft_data,
    output logic [BE_W-1:0]               be,
    output logic                          wr_n,
    output logic                          ft_oe,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [31:0]                   words_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, WAIT_TXE, WRITE} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     count;
    logic [TW-1:0]     idle_timer;
    logic [BW-1:0]     burst_cnt;
    logic              push, pop, accept, fifo_empty, start, burst_more;
    logic              wr_n_next, ft_oe_next;

    // s_ready is held low during reset so nothing is pushed into a FIFO being cleared.
    assign s_ready    = rst_n && (count != LW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign fifo_empty = (count == '0);
    assign accept     = !wr_n && !txe_n;
    assign level      = count;

    // FIFO storage write
    // NOTE: the storage array has no reset; occupancy is tracked by count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // FIFO pointers and occupancy
    // NOTE: sequential state is updated with non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Idle timer: runs while words wait in IDLE, restarts on push or on leaving IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_timer <= '0;
        end else if (state != IDLE || push || fifo_empty || start) begin
            idle_timer <= '0;
        end else if (idle_timer != TW'(TIMEOUT)) begin
            idle_timer <= idle_timer + TW'(1);
        end
    end

    // Burst length and lifetime accept counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt  <= '0;
            words_sent <= '0;
        end else begin
            if (state == IDLE && start) burst_cnt <= '0;
            else if (accept)            burst_cnt <= burst_cnt + BW'(1);
            if (accept) words_sent <= words_sent + 32'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state and FIFO pop decision
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        start      = (count >= LW'(BURST_MIN)) ||
                     (!fifo_empty && idle_timer == TW'(TIMEOUT));
        burst_more = (32'(burst_cnt) + 32'd1) < 32'(MAX_BURST);
        case (state)
            IDLE: begin
                if (start) begin
                    pop        = 1'b1;
                    state_next = WAIT_TXE;
                end
            end
            WAIT_TXE: begin
                if (!txe_n) state_next = WRITE;
            end
            WRITE: begin
                if (txe_n)                          state_next = WAIT_TXE;
                else if (burst_more && !fifo_empty) pop        = 1'b1;
                else                                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: pin values for the state being entered, registered below
    always_comb begin
        wr_n_next  = (state_next != WRITE);
        ft_oe_next = (state_next != IDLE);
    end

    // Registered FT600 pin outputs; ft_data only changes on a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n    <= 1'b1;
            be      <= '0;
            ft_oe   <= 1'b0;
            ft_data <= '0;
        end else begin
            wr_n  <= wr_n_next;
            be    <= {BE_W{!wr_n_next}};
            ft_oe <= ft_oe_next;
            if (pop) ft_data <= mem[rd_ptr];
        end
    end

endmodule

// File: doc/ft_tx_stream.md
# ft_tx_stream

Same-clock streaming buffer and FT600 245-synchronous write engine that sits directly upstream of the FT600 pin driver. It accepts ADC samples over a valid/ready interface and buffers them in an internal FIFO. It drains them to the FT600 in bursts gated by `txe_n`, and drives `wr_n`, `be` and write data as registered outputs. The top level only adds the tri-state buffers, using `ft_oe`.

## Interface
- `DATA_W`, 16: sample and FT600 data width.
- `BE_W`, 2: byte-enable width.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two, at least 4.
- `BURST_MIN`, 8: FIFO level that starts a burst; range 1..`FIFO_DEPTH`.
- `MAX_BURST`, 64: maximum words accepted per burst before returning to IDLE.
- `TIMEOUT`, 255: idle cycles after which a partial FIFO (level > 0) is flushed.

Ports:
- `clk` in 1: single clock, the FT600 CLKOUT domain.
- `rst_n` in 1: reset, asynchronous assert, active low.
- `s_data` in `DATA_W`: sample in.
- `s_valid` in 1: sample valid.
- `s_ready` out 1: FIFO not full; forced 0 while `rst_n` = 0.
- `txe_n` in 1: FT600 transmit FIFO not-full, active low.
- `ft_data` out `DATA_W`: write data (registered).
- `be` out `BE_W`: byte enables (registered).
- `wr_n` out 1: write strobe, active low (registered).
- `ft_oe` out 1: tri-state enable for `ft_data`/`be` (registered).
- `level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `words_sent` out 32: count of words accepted by the FT600; wraps at 2^32.

## Operation
- Push: on an edge with `s_valid` & `s_ready`, write `s_data` to the FIFO.
  - `s_ready` = (`level` != `FIFO_DEPTH`).
  - When full, samples are not lost; the producer stalls.
- Pop: moves the FIFO head into the output register (`ft_data`).
  - A simultaneous push and pop leaves `level` unchanged.
  - A push into an empty FIFO is not poppable on the same edge.
- Accept: a word is accepted at an edge where registered `wr_n` = 0 and `txe_n` = 0. Each accept increments `words_sent` and the burst counter.
- FSM states:
  - IDLE
    - Outputs: `wr_n`=1, `ft_oe`=0, `be`=0.
    - The idle timer counts while `level` > 0 and clears on any push or on leaving IDLE.
    - Start condition: `level` ≥ `BURST_MIN`, or (`level` > 0 and idle timer = `TIMEOUT`).
    - On start: pop into the output register, clear the burst counter, go to WAIT_TXE.
  - WAIT_TXE
    - Outputs: `wr_n`=1, `ft_oe`=1; `ft_data` holds the pending word.
    - If `txe_n`=0: `wr_n`<=0, `be`<=all ones, go to WRITE. Otherwise stay.
  - WRITE
    - Outputs: `wr_n`=0, `be`=all ones.
    - `txe_n`=1: the word is not accepted. Hold `ft_data`, set `wr_n`<=1, `be`<=0, go to WAIT_TXE.
    - `txe_n`=0, burst count+1 < `MAX_BURST`, and FIFO not empty: pop the next word, stay.
    - `txe_n`=0 otherwise (burst limit reached or FIFO empty): set `wr_n`<=1, `be`<=0, `ft_oe`<=0, go to IDLE.
- `be` always equals `{BE_W{~wr_n}}` at the outputs.

## Timing
- Reset values: `wr_n`=1, `be`=0, `ft_oe`=0, `ft_data`=0, `level`=0, `words_sent`=0, FSM=IDLE, `s_ready`=0.
  - `s_ready` rises combinationally once `rst_n` = 1.
- Reset mid-burst: outputs return to their reset values immediately. FIFO contents and the pending word are discarded.
- Latency with `BURST_MIN`=1 and `txe_n` held low:
  - Push at edge N.
  - IDLE start/pop at edge N+1.
  - `wr_n` low after edge N+2.
  - Word accepted at edge N+3.
- Throughput: one word per clock in WRITE while `txe_n`=0 and the FIFO is non-empty.
- `txe_n` is not registered before use. Its effect on `wr_n` appears one edge later, so at most one non-accepted strobe cycle occurs per `txe_n` rise.
- Burst boundary: after `MAX_BURST` accepts, `wr_n` is high for at least 2 cycles (IDLE, WAIT_TXE) before the next strobe.

## Test plan
- Reset, then push 8 words 0x0001..0x0008 with `txe_n`=0.
  - Expect `wr_n` low for exactly 8 consecutive cycles.
  - Expect accepted data 0x0001..0x0008 in order, `words_sent`=8, `level`=0, `be`=2'b11 during strobe.
- Push 3 words with `BURST_MIN`=8 and no further input.
  - Expect no strobe for 255 idle cycles, then a 3-word burst.
- Hold `txe_n`=1, push 20 words.
  - Expect `s_ready`=0 once `level`=16.
  - Expect no words lost.
  - After `txe_n`=0, expect all 17 words (16 FIFO + 1 pending) then the remaining 3, in order.
- During a burst, pulse `txe_n` high for 2 cycles after accepting word 0x0005.
  - Expect 0x0006 held on `ft_data` with `wr_n`=1.
  - Expect it accepted exactly once after `txe_n` returns low; no duplicates or gaps.
- Continuous input with `MAX_BURST`=64.
  - Expect bursts of exactly 64 accepts separated by ≥2 cycles of `wr_n`=1.
- Assert `rst_n` low mid-burst.
  - Expect `wr_n`=1, `be`=0, `ft_oe`=0 asynchronously, and `level`=0.
